ps2_key_controller: RTL and testbench
=====================================

PS2_KEY_CONTROLLER -- requirements
Module: ps2_key_controller

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, event FIFO depth in entries; SHALL be a power of two, 2..64.
REQ-002 Parameter PREFIX_TIMEOUT, default 50000, clk cycles a pending prefix is held before it is discarded.
REQ-003 clk  input  1  system clock (50 MHz); all state SHALL be clocked on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 key_byte  input  8  scancode byte from the PS/2 receiver; asynchronous to clk, stable while key_strobe is high.
REQ-006 key_strobe  input  1  byte-ready level from the receiver, asynchronous to clk; a rising edge marks a new byte.
REQ-007 rd_en  input  1  pop request from the CPU side.
REQ-008 clear_overflow  input  1  clears the sticky overflow flag.
REQ-009 event_out  output  16  FIFO head, first-word fall-through: [15] break, [14] extended (E0), [13] system byte, [12:8] zero, [7:0] code.
REQ-010 event_valid  output  1  high while the FIFO is non-empty.
REQ-011 event_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  output  1  sticky flag; an event was dropped because the FIFO was full.

Function
REQ-013 key_strobe SHALL pass through a 2-flop synchronizer, then a third edge-detect flop; a byte SHALL be accepted only on a synchronized 0->1 transition.
REQ-014 key_byte SHALL be captured on the same clk edge that the synchronized rising edge is detected; no other synchronization of key_byte is required.
REQ-015 Latency: with key_strobe first sampled high at clk edge N, the resulting event SHALL be visible on event_out/event_valid after edge N+3 (FIFO previously empty).
REQ-016 Prefix FSM states: IDLE, GOT_E0, GOT_F0, GOT_E0F0.
REQ-017 IDLE: E0 -> GOT_E0; F0 -> GOT_F0; 00 or FF -> discarded, stay IDLE; AA, FA, EE, FC, FD -> emit with [13]=1, [15:14]=0, stay IDLE; any other byte -> emit make event ([15:13]=0), stay IDLE.
REQ-018 GOT_E0: F0 -> GOT_E0F0; E0 -> stay GOT_E0; any other byte -> emit {break=0, ext=1}, go IDLE.
REQ-019 GOT_F0: any byte other than E0/F0 -> emit {break=1, ext=0}, go IDLE; E0 or F0 -> discarded, go IDLE.
REQ-020 GOT_E0F0: any byte other than E0/F0 -> emit {break=1, ext=1}, go IDLE; E0 or F0 -> discarded, go IDLE.
REQ-021 Timeout counter SHALL clear on every accepted byte and count while the FSM is not in IDLE; at count == PREFIX_TIMEOUT the FSM SHALL return to IDLE with no event emitted.
REQ-022 Emitted events SHALL be written to the FIFO on the clk edge the byte is accepted.
REQ-023 Write while full and no pop: event dropped, overflow set, FIFO contents unchanged.
REQ-024 Write and pop on the same edge while full: pop and write both take effect, occupancy unchanged, overflow not set.
REQ-025 Write and pop on the same edge while empty: only the write takes effect; rd_en is ignored whenever event_valid is low.
REQ-026 Pointers SHALL wrap modulo FIFO_DEPTH; event_count SHALL range 0..FIFO_DEPTH inclusive.
REQ-027 clear_overflow SHALL clear overflow on the next edge; if an overflow drop occurs on the same edge, set wins.

Reset
REQ-028 While rst is high: FSM = IDLE; timeout counter = 0; FIFO pointers and count = 0; overflow = 0; event_valid = 0; event_out = 0.
REQ-029 All synchronizer and edge-detect flops SHALL reset to 1, so a key_strobe held high across reset deassertion produces no event.
REQ-030 rst asserted mid-prefix or with a strobe in flight SHALL discard the partial sequence; no event may be emitted from pre-reset bytes.

Verification
REQ-031 Byte 1C strobed into an empty FIFO -> after edge N+3, event_valid=1, event_out=0x001C, event_count=1.
REQ-032 Sequence E0, F0, 75 -> a single event 0xC075; bytes F0, 1C -> 0x801C; byte AA -> 0x20AA.
REQ-033 E0 followed by no byte for PREFIX_TIMEOUT+1 cycles, then 1C -> event 0x001C (extended bit clear).
REQ-034 FIFO_DEPTH+1 make events with no reads -> event_count=FIFO_DEPTH, overflow=1, head is the first event; pulse clear_overflow -> overflow=0.
REQ-035 FIFO full, rd_en held high while a new byte is accepted -> count unchanged, overflow stays 0, the new event appears last in read order.
REQ-036 rst pulsed after E0, with key_strobe held high through deassertion -> no event; next strobe of 1C -> 0x001C.

Source files
------------

// File: rtl/ps2_key_controller.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_controller
// Description : Decodes PS/2 set-2 scancode bytes (E0/F0 prefixes) into
//               16-bit key events and buffers them in a first-word
//               fall-through FIFO with a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_controller #(
   parameter int FIFO_DEPTH     = 8,
   parameter int PREFIX_TIMEOUT = 50000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    key_byte,
   input  logic                          key_strobe,
   input  logic                          rd_en,
   input  logic                          clear_overflow,
   output logic [15:0]                   event_out,
   output logic                          event_valid,
   output logic [$clog2(FIFO_DEPTH):0]   event_count,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
   localparam logic [AW:0]   c_full_count = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   c_one        = (AW+1)'(1);
   localparam logic [TW-1:0] c_tmo        = TW'(PREFIX_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GOT_E0  = 2'd1,
      ST_GOT_F0  = 2'd2,
      ST_GOT_E0F0 = 2'd3
   } state_t;

   logic          r_sync_meta;
   logic          r_sync;
   logic          r_sync_d;
   logic          w_rise;
   logic [7:0]    r_byte;
   logic          r_byte_vld;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [TW-1:0] r_tmo_cnt;
   logic          w_emit;
   logic [15:0]   w_evt;
   logic          w_is_prefix;
   logic          w_is_sys;

   logic [15:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;
   logic          w_full;
   logic          w_pop;
   logic          w_wr;
   logic          w_drop;

   // Synchronizer flops reset high so a strobe held across reset is not an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync_meta <= 1'b1;
         r_sync      <= 1'b1;
         r_sync_d    <= 1'b1;
         r_byte_vld  <= 1'b0;
         r_byte      <= 8'h00;
      end else begin
         r_sync_meta <= key_strobe;
         r_sync      <= r_sync_meta;
         r_sync_d    <= r_sync;
         r_byte_vld  <= w_rise;
         if (w_rise) begin
            r_byte <= key_byte;
         end
      end
   end

   assign w_rise = r_sync & ~r_sync_d;

   assign w_is_prefix = (r_byte == 8'hE0) || (r_byte == 8'hF0);
   assign w_is_sys    = (r_byte == 8'hAA) || (r_byte == 8'hFA) || (r_byte == 8'hEE) ||
                        (r_byte == 8'hFC) || (r_byte == 8'hFD);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_emit      = 1'b0;
      w_evt       = 16'h0000;
      if (r_byte_vld) begin
         case (r_state)
            ST_IDLE: begin
               if (r_byte == 8'hE0) begin
                  w_state_nxt = ST_GOT_E0;
               end else if (r_byte == 8'hF0) begin
                  w_state_nxt = ST_GOT_F0;
               end else if ((r_byte == 8'h00) || (r_byte == 8'hFF)) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_is_sys) begin
                  w_emit = 1'b1;
                  w_evt  = {3'b001, 5'b00000, r_byte};
               end else begin
                  w_emit = 1'b1;
                  w_evt  = {3'b000, 5'b00000, r_byte};
               end
            end
            ST_GOT_E0: begin
               if (r_byte == 8'hF0) begin
                  w_state_nxt = ST_GOT_E0F0;
               end else if (r_byte == 8'hE0) begin
                  w_state_nxt = ST_GOT_E0;
               end else begin
                  w_emit      = 1'b1;
                  w_evt       = {3'b010, 5'b00000, r_byte};
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_GOT_F0: begin
               w_state_nxt = ST_IDLE;
               if (!w_is_prefix) begin
                  w_emit = 1'b1;
                  w_evt  = {3'b100, 5'b00000, r_byte};
               end
            end
            ST_GOT_E0F0: begin
               w_state_nxt = ST_IDLE;
               if (!w_is_prefix) begin
                  w_emit = 1'b1;
                  w_evt  = {3'b110, 5'b00000, r_byte};
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end else if ((r_state != ST_IDLE) && (r_tmo_cnt == c_tmo)) begin
         w_state_nxt = ST_IDLE;
      end
   end

   // A stale prefix is abandoned silently once it has waited PREFIX_TIMEOUT cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tmo_cnt <= '0;
      end else if (r_byte_vld || (r_state == ST_IDLE) || (r_tmo_cnt == c_tmo)) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
   end

   assign w_full = (r_count == c_full_count);
   assign w_pop  = rd_en && (r_count != '0);
   assign w_wr   = w_emit && (!w_full || w_pop);
   assign w_drop = w_emit && w_full && !w_pop;

   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= w_evt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + c_one;
            2'b01:   r_count <= r_count - c_one;
            default: r_count <= r_count;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clear_overflow) begin
            r_overflow <= 1'b0;
         end
      end
   end

   assign event_valid = (r_count != '0);
   assign event_out   = event_valid ? r_mem[r_rd_ptr] : 16'h0000;
   assign event_count = r_count;
   assign overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_controller
// Description : Scoreboard bench for ps2_key_controller; expected events are
//               queued by the stimulus and compared by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_controller;

   localparam int DEPTH = 8;
   localparam int TMO   = 20;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  key_byte = 8'h00;
   logic        key_strobe = 1'b0;
   logic        tb_rd = 1'b0;
   logic        mon_rd = 1'b0;
   logic        rd_en;
   logic        clear_overflow = 1'b0;
   logic [15:0] event_out;
   logic        event_valid;
   logic [3:0]  event_count;
   logic        overflow;

   int          total = 0;
   int          bad = 0;
   logic        drain = 1'b0;
   logic [15:0] exp_q [$];

   assign rd_en = tb_rd | mon_rd;

   always #5 clk = ~clk;

   ps2_key_controller #(
      .FIFO_DEPTH     (DEPTH),
      .PREFIX_TIMEOUT (TMO)
   ) u_dut (
      .clk            (clk),
      .rst            (rst),
      .key_byte       (key_byte),
      .key_strobe     (key_strobe),
      .rd_en          (rd_en),
      .clear_overflow (clear_overflow),
      .event_out      (event_out),
      .event_valid    (event_valid),
      .event_count    (event_count),
      .overflow       (overflow)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the DUT whenever draining is enabled and checks against the queue.
   initial begin
      logic [15:0] e;
      forever begin
         @(negedge clk);
         mon_rd = 1'b0;
         if (drain && event_valid) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_event: got %h expected none", event_out);
            end else begin
               e = exp_q.pop_front();
               chk("event", {16'h0, event_out}, {16'h0, e});
            end
            mon_rd = 1'b1;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1 key_byte = b;
      key_strobe = 1'b1;
      repeat (4) @(posedge clk);
      #1 key_strobe = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   // Strobe a byte and hold rd_en high for exactly the edge the byte is accepted.
   task automatic send_with_rd(input logic [7:0] b);
      @(posedge clk);
      #1 key_byte = b;
      key_strobe = 1'b1;
      repeat (3) @(posedge clk);
      #1 tb_rd = 1'b1;
      @(posedge clk);
      #1 tb_rd = 1'b0;
      key_strobe = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   task automatic wait_drain(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !event_valid) begin
            done = 1'b1;
            break;
         end
      end
      chk(name, {31'h0, done}, 32'h1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'h0, event_valid}, 32'h0);
      chk("rst_out",   {16'h0, event_out},   32'h0);
      chk("rst_count", {28'h0, event_count}, 32'h0);
      chk("rst_ovf",   {31'h0, overflow},    32'h0);
      rst = 1'b0;
      repeat (2) @(posedge clk);

      // Latency: strobe first sampled at edge N, event visible after N+3.
      @(posedge clk);
      #1 key_byte = 8'h1C;
      key_strobe = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("lat_early_valid", {31'h0, event_valid}, 32'h0);
      @(posedge clk);
      #1;
      chk("lat_valid", {31'h0, event_valid}, 32'h1);
      chk("lat_out",   {16'h0, event_out},   32'h001C);
      chk("lat_count", {28'h0, event_count}, 32'h1);
      key_strobe = 1'b0;
      repeat (4) @(posedge clk);
      exp_q.push_back(16'h001C);
      drain = 1'b1;
      wait_drain("drain_lat");

      // Prefix decoding.
      exp_q.push_back(16'hC075);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      exp_q.push_back(16'h801C);
      send_byte(8'hF0); send_byte(8'h1C);
      exp_q.push_back(16'h20AA);
      send_byte(8'hAA);
      exp_q.push_back(16'h4074);
      send_byte(8'hE0); send_byte(8'h74);
      send_byte(8'h00);
      send_byte(8'hFF);
      exp_q.push_back(16'h4012);
      send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h12);
      exp_q.push_back(16'h001D);
      send_byte(8'hF0); send_byte(8'hE0); send_byte(8'h1D);
      exp_q.push_back(16'h20FC);
      send_byte(8'hFC);
      exp_q.push_back(16'h8021);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'hF0); send_byte(8'hF0); send_byte(8'h21);
      wait_drain("drain_prefix");

      // Prefix timeout.
      send_byte(8'hE0);
      repeat (TMO + 1) @(posedge clk);
      exp_q.push_back(16'h001C);
      send_byte(8'h1C);
      wait_drain("drain_timeout");

      // Overflow with no reads.
      drain = 1'b0;
      for (int i = 0; i <= DEPTH; i++) send_byte(8'(8'h10 + i));
      #1;
      chk("full_count", {28'h0, event_count}, DEPTH);
      chk("full_ovf",   {31'h0, overflow},    32'h1);
      chk("full_head",  {16'h0, event_out},   32'h0010);
      @(posedge clk);
      #1 clear_overflow = 1'b1;
      @(posedge clk);
      #1 clear_overflow = 1'b0;
      chk("clr_ovf",    {31'h0, overflow},    32'h0);
      chk("clr_count",  {28'h0, event_count}, DEPTH);

      // Full FIFO, pop and write on the same edge.
      send_with_rd(8'h19);
      chk("fullrw_count", {28'h0, event_count}, DEPTH);
      chk("fullrw_ovf",   {31'h0, overflow},    32'h0);
      chk("fullrw_head",  {16'h0, event_out},   32'h0011);
      for (int i = 1; i < DEPTH; i++) exp_q.push_back(16'(16'h0010 + i));
      exp_q.push_back(16'h0019);
      drain = 1'b1;
      wait_drain("drain_full");

      // Empty FIFO, pop and write on the same edge: only the write counts.
      drain = 1'b0;
      send_with_rd(8'h2A);
      chk("emptyrw_count", {28'h0, event_count}, 32'h1);
      chk("emptyrw_out",   {16'h0, event_out},   32'h002A);
      exp_q.push_back(16'h002A);
      drain = 1'b1;
      wait_drain("drain_empty");

      // Reset mid-prefix with the strobe held high through deassertion.
      @(posedge clk);
      #1 key_byte = 8'hE0;
      key_strobe = 1'b1;
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk("rstheld_valid", {31'h0, event_valid}, 32'h0);
      chk("rstheld_count", {28'h0, event_count}, 32'h0);
      key_strobe = 1'b0;
      repeat (4) @(posedge clk);
      exp_q.push_back(16'h001C);
      send_byte(8'h1C);
      wait_drain("drain_rst");
      chk("end_ovf", {31'h0, overflow}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
